intext_accum: RTL
=================

Name: intext_accum

Overview:
- Widening counterpart to the control loop's saturating truncator (intsat, OUT_LEN -> IN_LEN).
- Takes narrow signed samples, sign-extends them to OUT_LEN bits and accumulates them into a wide register, saturating at the wide signed limits.
- Sits on the integrator path of the control loop, upstream of intsat, which narrows the result again.
- Input uses a valid/ready handshake; output is a one-cycle valid pulse per accepted sample.

Parameters:
- IN_LEN, 32: width of the narrow signed input sample.
- OUT_LEN, 64: width of the signed accumulator and output; must be greater than IN_LEN.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_L  input  1  asynchronous active-low reset.
- in_val  input  IN_LEN  signed narrow sample.
- in_valid  input  1  in_val is valid.
- in_ready  output  1  block can accept a sample.
- clear  input  1  zero the accumulator.
- out_val  output  OUT_LEN  signed accumulated value.
- out_valid  output  1  one-cycle pulse; out_val updated this cycle.
- saturated  output  1  last accumulation hit a signed limit.

Behaviour:
- Reset (rst_L low, asynchronous): state=WAIT_IN, accumulator=0, out_val=0, out_valid=0, in_ready=0, saturated=0, internal sample register=0.
- The first clock after reset release enters WAIT_IN with in_ready=1.
- FSM states and transitions:
  - WAIT_IN: in_ready=1. On in_valid&in_ready, capture in_val and go to EXTEND.
  - EXTEND: in_ready=0. Sign-extend the captured sample to OUT_LEN by replicating its bit IN_LEN-1, register it, go to ACCUM.
  - ACCUM: compute an OUT_LEN+1 bit sum of the accumulator and the extended sample.
    - If the top two bits differ, clamp to 2^(OUT_LEN-1)-1 (positive overflow) or -2^(OUT_LEN-1) (negative overflow) and set saturated=1.
    - Otherwise load the sum and set saturated=0.
    - Go to EMIT.
  - EMIT: out_val=accumulator, out_valid=1 for exactly this cycle, go to WAIT_IN.
- Latency: handshake cycle to out_valid is 3 cycles. Throughput is one sample per 4 cycles.
- clear:
  - Sampled every cycle; highest priority.
  - Zeroes the accumulator, out_val and saturated, and aborts any in-flight sample.
  - Forces WAIT_IN; out_valid=0 that cycle.
  - clear together with in_valid in WAIT_IN: the sample is dropped and in_ready reads 0 that cycle.
- Saturation holds: once clamped, further same-sign samples keep the value at the limit. An opposite-sign sample moves it off the limit and clears saturated.
- in_val is ignored outside WAIT_IN.
- Reset mid-operation discards the in-flight sample and returns to the reset values immediately.

Optional Feature:
- Macro: INTEXT_ACCUM_OVF_STICKY_EN.
- Defined:
  - Adds output port ovf_sticky (1 bit), reset 0.
  - Set on any ACCUM cycle that clamps; cleared only by clear or reset.
- Undefined:
  - Port and logic absent.
  - Only the per-update saturated flag exists.

Test Plan:
- Reset, then one sample in_val=410000000 -> out_valid pulses 3 cycles after the handshake, out_val=410000000, saturated=0.
- Samples +1 six times after 410000000 -> successive out_val of 410000001 through 410000006, each pulse 4 cycles apart.
- clear, then in_val=-1000000000 followed by -400095 -> out_val=-1000000000, then -1000400095; sign extension is correct (upper 32 bits all ones).
- Preload near the limit, then feed 32'h7FFFFFFF repeatedly -> out_val clamps at 64'h7FFFFFFFFFFFFFFF with saturated=1. One subsequent -1 gives 64'h7FFFFFFFFFFFFFFE with saturated=0; with the macro defined, ovf_sticky stays 1.
- Assert clear during ACCUM -> no out_valid for that sample, out_val=0, next sample 5 gives out_val=5.
- Drop rst_L low mid-EXTEND, asynchronously and without a clock edge -> all outputs 0 immediately; after release, in_ready=1 on the first clock.

Source files
------------

// File: rtl/intext_accum.sv
// Sign-extending saturating accumulator: narrow signed samples summed into a wide signed register.
// Optional sticky overflow flag output enabled by defining INTEXT_ACCUM_OVF_STICKY_EN.
module intext_accum #(
  parameter int IN_LEN  = 32,
  parameter int OUT_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_L,
  input  logic [IN_LEN-1:0]  in_val,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               clear,
  output logic [OUT_LEN-1:0] out_val,
  output logic               out_valid,
  output logic               saturated
`ifdef INTEXT_ACCUM_OVF_STICKY_EN
  ,
  output logic               ovf_sticky
`endif
);

  localparam logic [OUT_LEN-1:0] SAT_MAX = {1'b0, {(OUT_LEN-1){1'b1}}};
  localparam logic [OUT_LEN-1:0] SAT_MIN = {1'b1, {(OUT_LEN-1){1'b0}}};

  typedef enum logic [1:0] {
    WAIT_IN = 2'd0,
    EXTEND  = 2'd1,
    ACCUM   = 2'd2,
    EMIT    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IN_LEN-1:0]    sample_q, sample_d;
  logic [OUT_LEN-1:0]   ext_q, ext_d;
  logic [OUT_LEN-1:0]   acc_q, acc_d;
  logic [OUT_LEN-1:0]   out_val_q, out_val_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 sat_q, sat_d;
  logic [OUT_LEN:0]     sum_s;
`ifdef INTEXT_ACCUM_OVF_STICKY_EN
  logic                 sticky_q, sticky_d;
`endif

  // in_ready is held low through reset and drops combinationally while clear is high
  assign in_ready  = in_ready_q & ~clear;
  assign out_valid = out_valid_q & ~clear;
  assign out_val   = out_val_q;
  assign saturated = sat_q;
`ifdef INTEXT_ACCUM_OVF_STICKY_EN
  assign ovf_sticky = sticky_q;
`endif

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    ext_d       = ext_q;
    acc_d       = acc_q;
    out_val_d   = out_val_q;
    out_valid_d = 1'b0;
    sat_d       = sat_q;
`ifdef INTEXT_ACCUM_OVF_STICKY_EN
    sticky_d    = sticky_q;
`endif
    // One guard bit: the top two bits differing means the signed sum left the OUT_LEN range
    sum_s = {acc_q[OUT_LEN-1], acc_q} + {ext_q[OUT_LEN-1], ext_q};

    if (clear) begin
      state_d   = WAIT_IN;
      acc_d     = {OUT_LEN{1'b0}};
      out_val_d = {OUT_LEN{1'b0}};
      sat_d     = 1'b0;
`ifdef INTEXT_ACCUM_OVF_STICKY_EN
      sticky_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        WAIT_IN: begin
          if (in_valid && in_ready_q) begin
            sample_d = in_val;
            state_d  = EXTEND;
          end else begin
            state_d  = WAIT_IN;
          end
        end
        EXTEND: begin
          ext_d   = {{(OUT_LEN-IN_LEN){sample_q[IN_LEN-1]}}, sample_q};
          state_d = ACCUM;
        end
        ACCUM: begin
          if (sum_s[OUT_LEN] != sum_s[OUT_LEN-1]) begin
            acc_d = sum_s[OUT_LEN] ? SAT_MIN : SAT_MAX;
            sat_d = 1'b1;
`ifdef INTEXT_ACCUM_OVF_STICKY_EN
            sticky_d = 1'b1;
`endif
          end else begin
            acc_d = sum_s[OUT_LEN-1:0];
            sat_d = 1'b0;
          end
          out_val_d   = acc_d;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end
        EMIT: begin
          state_d = WAIT_IN;
        end
        default: begin
          state_d = WAIT_IN;
        end
      endcase
    end

    in_ready_d = (state_d == WAIT_IN);
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= WAIT_IN;
      sample_q    <= {IN_LEN{1'b0}};
      ext_q       <= {OUT_LEN{1'b0}};
      acc_q       <= {OUT_LEN{1'b0}};
      out_val_q   <= {OUT_LEN{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      sat_q       <= 1'b0;
`ifdef INTEXT_ACCUM_OVF_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      ext_q       <= ext_d;
      acc_q       <= acc_d;
      out_val_q   <= out_val_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      sat_q       <= sat_d;
`ifdef INTEXT_ACCUM_OVF_STICKY_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

endmodule
